// File: rtl/eq_clkgen.sv
// Quadrature E/Q clock generator for the 6809E: divides CLKX4 by four into E and Q,
// stretches the E-high/Q-low phase while MRDY is low, and bounds each stretch.
module eq_clkgen #(
   parameter int MAX_STRETCH = 10
) (
   input  logic       CLKX4,
   input  logic       nRESET,
   input  logic       RUN,
   input  logic       MRDY,
   input  logic       TO_CLR,
   output logic       E,
   output logic       Q,
   output logic [1:0] PHASE,
   output logic       CYCLE_END,
   output logic       STRETCH,
   output logic       TIMEOUT
);

   localparam int CW = $clog2(MAX_STRETCH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STRETCH);

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2,
      P3 = 2'd3
   } phase_t;

   phase_t        state;
   phase_t        state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          mrdy_r;
   logic          stretch_nx;
   logic          cycle_end_nx;
   logic          timeout_nx;
   logic          e_nx;
   logic          q_nx;

   // State, counter and every output are flops; E/Q come from the next state so they never glitch.
   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         state     <= P0;
         cnt       <= '0;
         mrdy_r    <= 1'b1;
         E         <= 1'b0;
         Q         <= 1'b0;
         CYCLE_END <= 1'b0;
         STRETCH   <= 1'b0;
         TIMEOUT   <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         mrdy_r    <= MRDY;
         E         <= e_nx;
         Q         <= q_nx;
         CYCLE_END <= cycle_end_nx;
         STRETCH   <= stretch_nx;
         TIMEOUT   <= timeout_nx;
      end
   end

   // P3 is the only decision point: hold while memory is not ready, force an exit at the count limit.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      stretch_nx   = STRETCH;
      cycle_end_nx = 1'b0;
      timeout_nx   = TIMEOUT & ~TO_CLR;
      case (state)
         P0: begin
            if (RUN) begin
               state_nx = P1;
            end
         end
         P1: state_nx = P2;
         P2: state_nx = P3;
         P3: begin
            if (!mrdy_r && (cnt < CNT_MAX)) begin
               cnt_nx     = cnt + CW'(1);
               stretch_nx = 1'b1;
            end else begin
               state_nx     = P0;
               cnt_nx       = '0;
               stretch_nx   = 1'b0;
               cycle_end_nx = 1'b1;
               if (!mrdy_r) begin
                  timeout_nx = 1'b1;
               end
            end
         end
         default: state_nx = P0;
      endcase
      e_nx = (state_nx == P2) || (state_nx == P3);
      q_nx = (state_nx == P1) || (state_nx == P2);
   end

   assign PHASE = state;

endmodule

// File: doc/eq_clkgen.md
# eq_clkgen

Quadrature E/Q clock generator for the 6809E CPU on the SBC09 CPLD. It divides CLKX4 by four into E and Q, with Q leading E by one CLKX4 period. It stretches the bus cycle, E high and Q low, while MRDY is low, and bounds every stretch with a timeout. Its E/Q outputs feed the memory-mapping/decode block and the top level, which tristates them onto EX/QX.

## Interface
- MAX_STRETCH, 10: maximum extra CLKX4 periods added to one bus cycle by MRDY; range 1..255.
- CW, $clog2(MAX_STRETCH+1): width of the stretch counter. Derived, not overridden.

Ports:
- CLKX4  in  1  the only clock; all flops on its rising edge.
- nRESET  in  1  reset, asynchronous and active-low.
- RUN  in  1  clock enable. Low parks E/Q after the current cycle completes.
- MRDY  in  1  memory ready, active-high; low requests a stretch.
- TO_CLR  in  1  synchronous clear of TIMEOUT.
- E  out  1  6809 E clock.
- Q  out  1  6809 Q clock.
- PHASE  out  2  current phase: 0=P0, 1=P1, 2=P2, 3=P3.
- CYCLE_END  out  1  one-CLKX4 pulse in the tick E falls.
- STRETCH  out  1  high while E is held beyond its normal high time.
- TIMEOUT  out  1  sticky flag: a stretch was force-terminated.

## Operation
- Four states, Gray-sequenced: P0 (E=0,Q=0) -> P1 (0,1) -> P2 (1,1) -> P3 (1,0) -> P0.
- E and Q are registered flops, not decoded, so they are glitch-free. Exactly one of E or Q toggles per transition.
- MRDY_r register: captures MRDY every edge; reset value 1.
- P0: if RUN=1, go to P1; else stay in P0 (parked).
- P1 -> P2 and P2 -> P3 are unconditional. RUN is ignored mid-cycle.
- P3 exit rule:
  - If MRDY_r=0 and cnt<MAX_STRETCH: stay in P3, cnt<=cnt+1, STRETCH<=1.
  - If MRDY_r=0 and cnt==MAX_STRETCH: go to P0 and set TIMEOUT.
  - If MRDY_r=1: go to P0.
  - On any exit to P0: cnt<=0, STRETCH<=0, CYCLE_END<=1.
- CYCLE_END is high only in the first tick after a P3 -> P0 transition; otherwise 0.
- TIMEOUT: set by forced exit; cleared by TO_CLR=1. If set and clear happen in the same tick, set wins.
- cnt counts from 0 to MAX_STRETCH and never wraps.
- Reset values (asynchronous): P0, E=0, Q=0, PHASE=0, CYCLE_END=0, STRETCH=0, TIMEOUT=0, cnt=0, MRDY_r=1.
- Reset asserted mid-cycle or mid-stretch drops E and Q to 0 immediately. No partial cycle resumes.

## Timing
- Unstretched cycle: 4 CLKX4 periods. E is high for 2, Q is high for 2, and Q rises 1 period before E.
- After nRESET deasserts with RUN=1:
  - edge 1: Q=1.
  - edge 2: E=1.
  - edge 3: Q=0.
  - edge 4: E=0 and CYCLE_END=1.
- MRDY setup: MRDY must be low at the edge that drops Q (P2 -> P3) to stretch the current cycle. MRDY going low later stretches from the next evaluation point onward.
- Stretch of N periods: E high for 2+N periods. Q stays low throughout the stretch.
- Release latency: MRDY high sampled at edge m means E falls at edge m+1.
- Maximum cycle length: 4+MAX_STRETCH periods.
- RUN=0 sampled in P0 keeps E=Q=0. RUN=1 sampled in P0 raises Q at that same edge.
- RUN dropped mid-cycle takes effect only on reaching P0.
- Minimum parked time: 1 period, the normal P0.

## Test plan
- Free run: RUN=1, MRDY=1, 40 edges after reset. Require:
  - exactly 10 E periods of 4 ticks each;
  - Q rising 1 tick before E;
  - 10 CYCLE_END pulses, each 1 tick wide;
  - STRETCH=0 throughout.
- Stretch by 3: MRDY=0 at the P2->P3 edge, held for 3 edges, then 1. Require:
  - E high for 5 ticks;
  - Q low throughout;
  - STRETCH high for 3 ticks;
  - cycle length 7;
  - TIMEOUT=0.
- Timeout: MAX_STRETCH=10, MRDY held 0 indefinitely. Require:
  - every cycle is 14 ticks long;
  - TIMEOUT=1 from the first E fall;
  - TO_CLR pulsed during P1 leaves TIMEOUT at 0 only until the next forced exit;
  - a set/clear collision yields TIMEOUT=1.
- RUN gating: RUN=0 asserted in P1. Require:
  - the cycle completes normally;
  - E=Q=0 is held;
  - PHASE=0.
  - Then RUN=1 gives Q=1 at the first edge sampling it.
- Reset mid-stretch: assert nRESET=0 with E=1, cnt=5. Require:
  - E, Q, STRETCH and cnt are 0 asynchronously, without waiting for an edge;
  - after release, the first edge gives Q=1 and the stretch count starts from 0.
- Glitch check: over a 1000-tick run with random MRDY/RUN, no edge toggles both E and Q.
